// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory address/data, decode back-pressure and
// redirect inputs, and the IF/ID pipeline register outputs.
interface fetch_unit_if #(
  parameter int ADDR_W = 5,
  parameter int INST_W = 32
);
  logic [ADDR_W-1:0] imem_addr;
  logic [INST_W-1:0] imem_instruction;
  logic              stall;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_target;
  logic              if_id_valid;
  logic [INST_W-1:0] if_id_instruction;
  logic [ADDR_W-1:0] if_id_pc;

  modport master (
    output imem_addr, if_id_valid, if_id_instruction, if_id_pc,
    input  imem_instruction, stall, redirect_valid, redirect_target
  );

  modport slave (
    input  imem_addr, if_id_valid, if_id_instruction, if_id_pc,
    output imem_instruction, stall, redirect_valid, redirect_target
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory and fills IF/ID.
// Define FETCH_DELAY_SLOT_EN to keep the delay-slot instruction on redirect instead of flushing.
module fetch_unit #(
  parameter int                 ADDR_W   = 5,
  parameter int                 INST_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = {ADDR_W{1'b0}},
  parameter logic [INST_W-1:0]  NOP_WORD = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  output logic [1:0]          fetch_state_o,
  fetch_unit_if.master        bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              valid_q, valid_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [ADDR_W-1:0] idpc_q, idpc_d;

  // State, PC and IF/ID register; reset clears IF/ID immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      inst_q  <= NOP_WORD;
      idpc_q  <= {ADDR_W{1'b0}};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      inst_q  <= inst_d;
      idpc_q  <= idpc_d;
    end
  end

  // Next-state, next-PC and IF/ID load; redirect has priority over stall.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    inst_d  = inst_q;
    idpc_d  = idpc_q;
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        inst_d  = NOP_WORD;
        if (start_i) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN, HOLD: begin
        if (bus.redirect_valid) begin
          state_d = RUN;
          pc_d    = bus.redirect_target;
`ifdef FETCH_DELAY_SLOT_EN
          valid_d = 1'b1;
          inst_d  = bus.imem_instruction;
          idpc_d  = pc_q;
`else
          valid_d = 1'b0;
          inst_d  = NOP_WORD;
`endif
        end else if (bus.stall) begin
          state_d = HOLD;
        end else begin
          // Leaving HOLD fetches on the same edge so no slot is lost.
          state_d = RUN;
          pc_d    = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          valid_d = 1'b1;
          inst_d  = bus.imem_instruction;
          idpc_d  = pc_q;
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = RESET_PC;
        valid_d = 1'b0;
        inst_d  = NOP_WORD;
        idpc_d  = {ADDR_W{1'b0}};
      end
    endcase
  end

  assign bus.imem_addr         = pc_q;
  assign bus.if_id_valid       = valid_q;
  assign bus.if_id_instruction = inst_q;
  assign bus.if_id_pc          = idpc_q;
  assign fetch_state_o         = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues expected IF/ID state per edge,
// a monitor pops and compares one entry just after every rising edge.
module tb_fetch_unit;

  localparam logic [1:0]  S_IDLE = 2'd0;
  localparam logic [1:0]  S_RUN  = 2'd1;
  localparam logic [1:0]  S_HOLD = 2'd2;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  typedef struct packed {
    logic        v;
    logic [31:0] ins;
    logic [4:0]  pc;
    logic        chk_pc;
    logic [1:0]  st;
    logic [4:0]  addr;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  fetch_state;
  logic [31:0] mem [32];
  exp_t        expq [$];
  int          n_cmp;
  int          n_bad;

  fetch_unit_if #(.ADDR_W(5), .INST_W(32)) ifc ();

  fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start),
    .fetch_state_o (fetch_state),
    .bus           (ifc.master)
  );

  assign ifc.imem_instruction = mem[ifc.imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, compared=%0d", n_cmp);
    $fatal(1);
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, expv);
    end
  endtask

  function automatic exp_t mk_exp(input logic v, input logic [31:0] ins, input logic [4:0] pc,
                                  input logic chk_pc, input logic [1:0] st, input logic [4:0] addr);
    exp_t e;
    e.v = v; e.ins = ins; e.pc = pc; e.chk_pc = chk_pc; e.st = st; e.addr = addr;
    return e;
  endfunction

  function automatic exp_t fe(input logic [4:0] a);
    logic [4:0] nxt;
    nxt = a + 5'd1;
    return mk_exp(1'b1, mem[a], a, 1'b1, S_RUN, nxt);
  endfunction

  function automatic exp_t flush(input logic [4:0] cur, input logic [4:0] tgt);
`ifdef FETCH_DELAY_SLOT_EN
    return mk_exp(1'b1, mem[cur], cur, 1'b1, S_RUN, tgt);
`else
    return mk_exp(1'b0, NOP, cur, 1'b0, S_RUN, tgt);
`endif
  endfunction

  task automatic cyc(input logic s, input logic sl, input logic rv, input logic [4:0] tg, input exp_t e);
    @(negedge clk);
    start               = s;
    ifc.stall           = sl;
    ifc.redirect_valid  = rv;
    ifc.redirect_target = tg;
    expq.push_back(e);
  endtask

  task automatic check_reset(input string tag);
    cmp({tag, "_valid"}, {31'd0, ifc.if_id_valid}, 32'd0);
    cmp({tag, "_inst"},  ifc.if_id_instruction, NOP);
    cmp({tag, "_pc"},    {27'd0, ifc.if_id_pc}, 32'd0);
    cmp({tag, "_state"}, {30'd0, fetch_state}, {30'd0, S_IDLE});
    cmp({tag, "_addr"},  {27'd0, ifc.imem_addr}, 32'd0);
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && expq.size() != 0; k++) @(posedge clk);
    #2;
    cmp("drain_queue_empty", expq.size(), 32'd0);
  endtask

  // Monitor: compare IF/ID, state and address against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() != 0) begin
        e = expq.pop_front();
        cmp("if_id_valid", {31'd0, ifc.if_id_valid}, {31'd0, e.v});
        cmp("fetch_state", {30'd0, fetch_state}, {30'd0, e.st});
        cmp("imem_addr",   {27'd0, ifc.imem_addr}, {27'd0, e.addr});
        if (e.v) cmp("if_id_instruction", ifc.if_id_instruction, e.ins);
        else     cmp("if_id_nop",         ifc.if_id_instruction, NOP);
        if (e.chk_pc) cmp("if_id_pc", {27'd0, ifc.if_id_pc}, {27'd0, e.pc});
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < 32; i++) mem[i] = 32'hA500_0000 + i;
    for (int i = 0; i < 3; i++) begin
      mem[i]     = 32'h2001_0003;
      mem[i + 3] = 32'h2002_0003;
      mem[i + 6] = 32'h0022_1818;
    end
    rst_n = 1'b0;
    start = 1'b0;
    ifc.stall = 1'b0;
    ifc.redirect_valid = 1'b0;
    ifc.redirect_target = 5'd0;
    repeat (2) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;

    // Idle: stall and redirect must be ignored, no valid without start.
    for (int i = 0; i < 10; i++)
      cyc(1'b0, (i == 3), (i == 5), 5'd9, mk_exp(1'b0, NOP, 5'd0, 1'b1, S_IDLE, 5'd0));
    cyc(1'b1, 1'b0, 1'b0, 5'd0, mk_exp(1'b0, NOP, 5'd0, 1'b1, S_RUN, 5'd0));

    for (int a = 0; a < 9; a++) cyc(1'b0, 1'b0, 1'b0, 5'd0, fe(5'(a)));

    // Reposition to reach if_id_pc=4, then stall three cycles.
    cyc(1'b0, 1'b0, 1'b1, 5'd3, flush(5'd9, 5'd3));
    cyc(1'b0, 1'b0, 1'b0, 5'd0, fe(5'd3));
    cyc(1'b0, 1'b0, 1'b0, 5'd0, fe(5'd4));
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 1'b1, 1'b0, 5'd0, mk_exp(1'b1, mem[4], 5'd4, 1'b1, S_HOLD, 5'd5));
    cyc(1'b0, 1'b0, 1'b0, 5'd0, fe(5'd5));

    // Redirect from pc=2 to 6.
    cyc(1'b0, 1'b0, 1'b1, 5'd2, flush(5'd6, 5'd2));
    cyc(1'b0, 1'b0, 1'b1, 5'd6, flush(5'd2, 5'd6));
    cyc(1'b0, 1'b0, 1'b0, 5'd0, fe(5'd6));

    // Stall + redirect in RUN, then in HOLD with target equal to pc.
    cyc(1'b0, 1'b1, 1'b1, 5'd0, flush(5'd7, 5'd0));
    cyc(1'b0, 1'b0, 1'b0, 5'd0, fe(5'd0));
    cyc(1'b0, 1'b1, 1'b0, 5'd0, mk_exp(1'b1, mem[0], 5'd0, 1'b1, S_HOLD, 5'd1));
    cyc(1'b0, 1'b1, 1'b1, 5'd1, flush(5'd1, 5'd1));
    cyc(1'b0, 1'b0, 1'b0, 5'd0, fe(5'd1));

    // Wrap-around 30, 31, 0, 1.
    cyc(1'b0, 1'b0, 1'b1, 5'd30, flush(5'd2, 5'd30));
    cyc(1'b0, 1'b0, 1'b0, 5'd0, fe(5'd30));
    cyc(1'b0, 1'b0, 1'b0, 5'd0, fe(5'd31));
    cyc(1'b0, 1'b0, 1'b0, 5'd0, fe(5'd0));
    cyc(1'b0, 1'b0, 1'b0, 5'd0, fe(5'd1));
    drain();

    // Asynchronous reset mid-cycle while fetching.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 1'b0, 1'b0, 5'd0, mk_exp(1'b0, NOP, 5'd0, 1'b1, S_IDLE, 5'd0));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
